imm_extend_unit: RTL

//  Parametrised, registered immediate generator for the accumulator datapath. It widens an
//  IN_W-bit instruction immediate to OUT_W bits by sign-extension, zero-extension or upper-shift.
//  It also supports a two-instruction long immediate: a PREFIX op supplies the top OUT_W-IN_W bits
//  of the next immediate. Sits between decode and the ALU B-mux; one-cycle registered latency.

---
 rtl/imm_pkg.sv | 16 +
 rtl/imm_extend_unit_if.sv | 27 ++
 rtl/imm_extend_unit_widen.sv | 32 +++
 rtl/imm_extend_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: instruction mode field and control FSM states.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT   = 2'b00,
    IMM_ZEXT   = 2'b01,
    IMM_SHL    = 2'b10,
    IMM_PREFIX = 2'b11
  } imm_mode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PREFIXED = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Decode-side bundle of the immediate generator: request, pipeline control and registered result.
interface imm_extend_unit_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
);
  import imm_pkg::*;

  logic              in_valid;
  imm_mode_e         mode;
  logic [IN_W-1:0]   imm_in;
  logic              stall;
  logic              flush;
  logic [OUT_W-1:0]  imm_out;
  logic              out_valid;
  logic              prefix_pend;

  modport master (
    output in_valid, mode, imm_in, stall, flush,
    input  imm_out, out_valid, prefix_pend
  );

  modport slave (
    input  in_valid, mode, imm_in, stall, flush,
    output imm_out, out_valid, prefix_pend
  );

endinterface

// File: rtl/imm_extend_unit_widen.sv
// imm_widen: combinational IN_W -> OUT_W widening; a pending prefix replaces the top bits of SEXT/ZEXT.
module imm_widen
  import imm_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
) (
  input  imm_mode_e             mode,
  input  logic                  use_prefix,
  input  logic [OUT_W-IN_W-1:0] prefix,
  input  logic [IN_W-1:0]       imm,
  output logic [OUT_W-1:0]      val
);

  localparam int P_W = OUT_W - IN_W;

  // Select the widened value; mode 11 reaching here is treated as a sign-extend
  always_comb begin
    val = {{P_W{imm[IN_W-1]}}, imm};
    if (use_prefix && (mode != IMM_SHL)) begin
      val = {prefix, imm};
    end else begin
      case (mode)
        IMM_SEXT: val = {{P_W{imm[IN_W-1]}}, imm};
        IMM_ZEXT: val = {{P_W{1'b0}}, imm};
        IMM_SHL:  val = {imm, {P_W{1'b0}}};
        default:  val = {{P_W{imm[IN_W-1]}}, imm};
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate generator with stall/flush control. Define IMM_PREFIX_EN to build the
// PREFIX long-immediate mode and its IDLE/PREFIXED FSM; otherwise mode 11 acts as SEXT.
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
) (
  input  logic clk,
  input  logic reset,
  imm_extend_unit_if.slave bus
);

  localparam int P_W = OUT_W - IN_W;

  logic [OUT_W-1:0] imm_r;
  logic [OUT_W-1:0] imm_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic [OUT_W-1:0] widen_s;
  logic             use_prefix_s;
  logic [P_W-1:0]   prefix_s;

`ifdef IMM_PREFIX_EN
  imm_state_e     state_r;
  imm_state_e     state_nxt_s;
  logic [P_W-1:0] prefix_r;
  logic [P_W-1:0] prefix_nxt_s;

  assign use_prefix_s = (state_r == ST_PREFIXED);
  assign prefix_s     = prefix_r;
`else
  assign use_prefix_s = 1'b0;
  assign prefix_s     = {P_W{1'b0}};
`endif

  imm_widen #(.IN_W(IN_W), .OUT_W(OUT_W)) u_widen (
    .mode       (bus.mode),
    .use_prefix (use_prefix_s),
    .prefix     (prefix_s),
    .imm        (bus.imm_in),
    .val        (widen_s)
  );

  // Next-state and output decode; priority flush > stall > normal operation
  always_comb begin
    imm_nxt_s   = imm_r;
    valid_nxt_s = valid_r;
`ifdef IMM_PREFIX_EN
    state_nxt_s  = state_r;
    prefix_nxt_s = prefix_r;
`endif
    if (bus.flush) begin
      valid_nxt_s = 1'b0;
`ifdef IMM_PREFIX_EN
      state_nxt_s = ST_IDLE;
`endif
    end else if (bus.stall) begin
      valid_nxt_s = valid_r;
    end else if (!bus.in_valid) begin
      valid_nxt_s = 1'b0;
`ifdef IMM_PREFIX_EN
    end else if (bus.mode == IMM_PREFIX) begin
      valid_nxt_s  = 1'b0;
      prefix_nxt_s = bus.imm_in[P_W-1:0];
      state_nxt_s  = ST_PREFIXED;
`endif
    end else begin
      imm_nxt_s   = widen_s;
      valid_nxt_s = 1'b1;
`ifdef IMM_PREFIX_EN
      state_nxt_s = ST_IDLE;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_r   <= {OUT_W{1'b0}};
      valid_r <= 1'b0;
`ifdef IMM_PREFIX_EN
      state_r  <= ST_IDLE;
      prefix_r <= {P_W{1'b0}};
`endif
    end else begin
      imm_r   <= imm_nxt_s;
      valid_r <= valid_nxt_s;
`ifdef IMM_PREFIX_EN
      state_r  <= state_nxt_s;
      prefix_r <= prefix_nxt_s;
`endif
    end
  end

  assign bus.imm_out   = imm_r;
  assign bus.out_valid = valid_r;
`ifdef IMM_PREFIX_EN
  assign bus.prefix_pend = (state_r == ST_PREFIXED);
`else
  assign bus.prefix_pend = 1'b0;
`endif

endmodule
